// File: rtl/yblock_wb_bridge.sv
// Wishbone classic slave that drives a yblock's reset, data inputs and config
// shift port, and samples its 48 asynchronous outputs with change tracking.
module yblock_wb_bridge #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          PULSE    = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        blk_reset,
  output logic        blk_cclk,
  output logic [15:0] blk_cfg,
  output logic [31:0] blk_in,
  input  logic [47:0] blk_out
);

  localparam logic [3:0] PULSE_LAST = 4'(PULSE - 1);

  typedef enum logic [1:0] {IDLE, LOAD, HIGH, LOW} state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      state, state_nxt;
  logic [3:0]  tmr, tmr_nxt;
  logic        pop;

  logic [15:0] cfg_mem [16];
  logic [3:0]  wr_ptr, rd_ptr;
  logic [4:0]  fifo_cnt;
  logic [15:0] cfg_hold;

  logic [47:0] blk_out_p0, blk_out_p1, blk_out_p2;
  logic        chg, ovf;
  logic [15:0] chg_cnt;

  logic        accept, wr, in_win;
  logic [2:0]  ofs;
  logic        ctrl_wr, cfg_wr, din_wr, stat_wr;
  logic        blk_reset_nxt, start, busy, abort, full, push, chg_set;
  logic [15:0] cfg_data;
  logic [3:0]  cnt_disp;
  logic [31:0] rdata;
  logic        unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];

  // Bus decode: one acceptance per ack, so a held strobe cannot double-ack
  assign in_win  = (wbs_adr_i[31:5] == BASE_ADR[31:5]);
  assign accept  = wbs_stb_i & wbs_cyc_i & in_win & ~wbs_ack_o;
  assign wr      = accept & wbs_we_i;
  assign ofs     = wbs_adr_i[4:2];
  assign ctrl_wr = wr & (ofs == 3'd0) & wbs_sel_i[0];
  assign cfg_wr  = wr & (ofs == 3'd1) & (|wbs_sel_i[1:0]);
  assign din_wr  = wr & (ofs == 3'd2);
  assign stat_wr = wr & (ofs == 3'd5);

  assign cfg_data = {wbs_sel_i[1] ? wbs_dat_i[15:8] : 8'h00,
                     wbs_sel_i[0] ? wbs_dat_i[7:0]  : 8'h00};

  // A CTRL write carrying reset=1 both aborts a run and refuses to start one
  assign blk_reset_nxt = ctrl_wr ? wbs_dat_i[0] : blk_reset;
  assign start         = ctrl_wr & wbs_dat_i[1] & ~blk_reset_nxt;
  assign busy          = (state != IDLE);
  assign abort         = busy & blk_reset_nxt;

  assign full     = (fifo_cnt == 5'd16);
  assign push     = cfg_wr & ~full;
  assign cnt_disp = fifo_cnt[4] ? 4'hF : fifo_cnt[3:0];

  assign blk_cfg  = (state == LOAD) ? cfg_mem[rd_ptr] : cfg_hold;

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    pop       = 1'b0;
    case (state)
      IDLE: if (start && fifo_cnt != 5'd0) state_nxt = LOAD;
      LOAD: begin
        state_nxt = HIGH;
        tmr_nxt   = 4'd0;
      end
      HIGH: begin
        if (tmr == PULSE_LAST) begin
          state_nxt = LOW;
          tmr_nxt   = 4'd0;
        end else begin
          tmr_nxt = tmr + 4'd1;
        end
      end
      LOW: begin
        if (tmr == PULSE_LAST) begin
          pop       = 1'b1;
          tmr_nxt   = 4'd0;
          state_nxt = (fifo_cnt > 5'd1 || push) ? LOAD : IDLE;
        end else begin
          tmr_nxt = tmr + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      tmr_nxt   = 4'd0;
      pop       = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state    <= IDLE;
      tmr      <= 4'd0;
      blk_cclk <= 1'b0;
      cfg_hold <= 16'h0000;
    end else begin
      state    <= state_nxt;
      tmr      <= tmr_nxt;
      blk_cclk <= (state_nxt == HIGH);
      if (state == LOAD) cfg_hold <= cfg_mem[rd_ptr];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) cfg_mem[wr_ptr] <= cfg_data;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wr_ptr   <= 4'd0;
      rd_ptr   <= 4'd0;
      fifo_cnt <= 5'd0;
    end else if (abort) begin
      wr_ptr   <= 4'd0;
      rd_ptr   <= 4'd0;
      fifo_cnt <= 5'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 4'd1;
      if (pop)  rd_ptr <= rd_ptr + 4'd1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 5'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 5'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Stage p0/p1: synchronizer; p2: previous sample for change detection
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      blk_out_p0 <= '0;
      blk_out_p1 <= '0;
      blk_out_p2 <= '0;
    end else begin
      blk_out_p0 <= blk_out;
      blk_out_p1 <= blk_out_p0;
      blk_out_p2 <= blk_out_p1;
    end
  end

  assign chg_set = (blk_out_p1 != blk_out_p2);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      chg     <= 1'b0;
      ovf     <= 1'b0;
      chg_cnt <= 16'h0000;
    end else begin
      chg <= chg_set | (chg & ~(stat_wr & wbs_dat_i[0]));
      ovf <= (cfg_wr & full) | (ovf & ~(stat_wr & wbs_dat_i[1]));
      if (chg_set)
        chg_cnt <= sat_inc((stat_wr && wbs_dat_i[16]) ? 16'h0000 : chg_cnt);
      else if (stat_wr && wbs_dat_i[16])
        chg_cnt <= 16'h0000;
    end
  end

  always_comb begin
    rdata = 32'h0;
    case (ofs)
      3'd0:    rdata = {24'h0, cnt_disp, 1'b0, busy, 1'b0, blk_reset};
      3'd2:    rdata = blk_in;
      3'd3:    rdata = blk_out_p1[31:0];
      3'd4:    rdata = {16'h0, blk_out_p1[47:32]};
      3'd5:    rdata = {chg_cnt, 14'h0, ovf, chg};
      default: rdata = 32'h0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'h0;
      blk_reset <= 1'b1;
      blk_in    <= 32'h0;
    end else begin
      wbs_ack_o <= accept;
      wbs_dat_o <= (accept && !wbs_we_i) ? rdata : 32'h0;
      blk_reset <= blk_reset_nxt;
      if (din_wr) begin
        for (int b = 0; b < 4; b++)
          if (wbs_sel_i[b]) blk_in[8*b +: 8] <= wbs_dat_i[8*b +: 8];
      end
    end
  end

endmodule
